// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding, the queued event
// record, and the key-code width helper.
// No logic and no ports; imported by keypad_scanner and its event FIFO user.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CONFIRM,
    ST_HELD,
    ST_WAIT_CLR
  } state_e;

  // Widest key index the event record can carry (256 keys).
  localparam int KEY_CODE_MAX_W = 8;

  typedef struct packed {
    logic                      is_release;
    logic [KEY_CODE_MAX_W-1:0] code;
  } key_evt_t;

  function automatic int code_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Purpose: small synchronous FIFO holding keypad events until the consumer takes them.
// Latency: a push is visible at the head one cycle later; never bypassed.
// Backpressure: a push while full without a same-cycle pop is dropped and flagged by a one-cycle overflow pulse.
// Ports: clock/reset; push_vld/push_dat write side; pop_rdy accepts the head;
//        pop_vld (not empty), pop_dat (head, zero when empty), overflow pulse.
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  // One extra pointer bit tells full from empty when the indices coincide.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;

  logic empty, full, pop, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && pop_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_vld && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = push_vld && full && !pop;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop_vld  = !empty;
  assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scans a row/column key matrix, debounces one key at a time, queues press/release events.
// Latency: row changes reach the FSM after 2 sync flops; decisions happen on the last cycle of each dwell.
// Backpressure: events wait in a FIFO_DEPTH FIFO; an event arriving while full is dropped with an overflow pulse.
// Ports: clock, reset (async, active-high); row sense in; col drive out;
//        key_valid/key_ready/key_code/key_release event handshake; overflow pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int  N_ROWS     = 4,
  parameter int  N_COLS     = 4,
  parameter int  SCAN_DIV   = 16,
  parameter int  DEBOUNCE   = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int CODE_W     = code_width(N_ROWS * N_COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] col,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              overflow
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = $clog2(N_COLS);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE + 1);

  state_e            state_q, state_d;
  logic [N_ROWS-1:0] sync1_q, sync1_d;
  logic [N_ROWS-1:0] sync2_q, sync2_d;
  logic [TW-1:0]     dwell_q, dwell_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [N_COLS-1:0] col_q, col_d;

  logic              dwell_last;
  logic [NW-1:0]     cnt_inc;
  logic [RW-1:0]     r_hit;
  logic [N_ROWS-1:0] row_mask;
  logic              evt_push, evt_rel;
  key_evt_t          evt_in, head;

  assign dwell_last = (dwell_q == TW'(SCAN_DIV - 1));
  assign cnt_inc    = cnt_q + NW'(1);
  assign row_mask   = N_ROWS'(1) << r_q;

  // Row index of the set bit; only meaningful when the sample is one-hot.
  always_comb begin
    r_hit = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (sync2_q[i]) r_hit = RW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    sync1_d  = row;
    sync2_d  = sync1_q;
    dwell_d  = dwell_last ? '0 : dwell_q + TW'(1);
    cnt_d    = cnt_q;
    c_d      = c_q;
    r_d      = r_q;
    evt_push = 1'b0;
    evt_rel  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Dwell timing restarts so the first column gets a full dwell.
        dwell_d = '0;
        cnt_d   = '0;
        if (|sync2_q) begin
          state_d = ST_SCAN;
          c_d     = '0;
        end
      end
      ST_SCAN: if (dwell_last) begin
        if (sync2_q == '0) begin
          if (c_q == CW'(N_COLS - 1)) state_d = ST_IDLE;
          else                        c_d     = c_q + CW'(1);
        end else if ($onehot(sync2_q)) begin
          r_d = r_hit;
          if (DEBOUNCE == 1) begin
            evt_push = 1'b1;
            cnt_d    = '0;
            state_d  = ST_HELD;
          end else begin
            cnt_d    = NW'(1);
            state_d  = ST_CONFIRM;
          end
        end else begin
          // Several rows on one column: cannot tell real keys from ghosts.
          cnt_d   = '0;
          state_d = ST_WAIT_CLR;
        end
      end
      ST_CONFIRM: if (dwell_last) begin
        if (sync2_q == row_mask) begin
          if (cnt_inc == NW'(DEBOUNCE)) begin
            evt_push = 1'b1;
            cnt_d    = '0;
            state_d  = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: if (dwell_last) begin
        // Only the captured row matters; other keys on this column are ignored.
        if (!sync2_q[r_q]) begin
          if (cnt_inc == NW'(DEBOUNCE)) begin
            evt_push = 1'b1;
            evt_rel  = 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_CLR: if (dwell_last) begin
        if (sync2_q == '0) begin
          if (cnt_inc == NW'(DEBOUNCE)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Column drive follows the next state so it is registered with it.
    if (state_d == ST_IDLE || state_d == ST_WAIT_CLR) col_d = '1;
    else                                               col_d = N_COLS'(1) << c_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      col_q   <= '1;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      r_q     <= r_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    evt_in.is_release = evt_rel;
    evt_in.code       = KEY_CODE_MAX_W'(32'(r_d) * N_COLS + 32'(c_d));
  end

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_evt_t))
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (evt_push),
    .push_dat (evt_in),
    .pop_rdy  (key_ready),
    .pop_vld  (key_valid),
    .pop_dat  (head),
    .overflow (overflow)
  );

  assign col         = col_q;
  assign key_code    = head.code[CODE_W-1:0];
  assign key_release = head.is_release;

  // Upper code bits are always zero for this matrix size.
  if (CODE_W < KEY_CODE_MAX_W) begin : g_code_hi
    logic unused_code_hi;
    assign unused_code_hi = |head.code[KEY_CODE_MAX_W-1:CODE_W];
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 default instance and a 3x5 instance, each
// driven by a simulated key matrix (row = OR of pressed keys on driven columns).
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: defaults (4x4)
  logic       reset_a, key_ready_a, key_valid_a, key_release_a, overflow_a;
  logic [3:0] row_a, col_a, key_code_a;
  logic [3:0] press_a [4];

  // Instance B: 3 rows x 5 columns
  logic       reset_b, key_ready_b, key_valid_b, key_release_b, overflow_b;
  logic [2:0] row_b;
  logic [4:0] col_b;
  logic [3:0] key_code_b;
  logic [4:0] press_b [3];

  keypad_scanner #(.N_ROWS(4), .N_COLS(4), .SCAN_DIV(16), .DEBOUNCE(4), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .reset(reset_a), .row(row_a), .col(col_a),
    .key_valid(key_valid_a), .key_ready(key_ready_a), .key_code(key_code_a),
    .key_release(key_release_a), .overflow(overflow_a));

  keypad_scanner #(.N_ROWS(3), .N_COLS(5)) dut_b (
    .clock(clock), .reset(reset_b), .row(row_b), .col(col_b),
    .key_valid(key_valid_b), .key_ready(key_ready_b), .key_code(key_code_b),
    .key_release(key_release_b), .overflow(overflow_b));

  always_comb begin
    row_a = '0;
    for (int r = 0; r < 4; r++) row_a[r] = |(press_a[r] & col_a);
  end
  always_comb begin
    row_b = '0;
    for (int r = 0; r < 3; r++) row_b[r] = |(press_b[r] & col_b);
  end

  // Consumer-side monitor, sampled on the falling edge.
  logic [31:0] obs_a [$];
  int          ovf_a  = 0;
  int          pops_b = 0;
  always @(negedge clock) begin
    if (!reset_a && key_valid_a && key_ready_a) obs_a.push_back({27'd0, key_release_a, key_code_a});
    if (overflow_a) ovf_a++;
    if (!reset_b && key_valid_b && key_ready_b) pops_b++;
  end

  int errors = 0;
  int checks = 0;
  int obs_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ev(input int rel, input int code);
    return 32'(rel * 16 + code);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int pending();
    return obs_a.size() - obs_rd;
  endfunction

  task automatic take(output logic [31:0] v);
    if (obs_rd < obs_a.size()) begin
      v = obs_a[obs_rd];
      obs_rd++;
    end else begin
      v = 32'hDEAD;
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && pending() < n; i++) cyc(1);
  endtask

  task automatic tap_a(input int r, input int c, input int hold, input int gap);
    press_a[r][c] = 1'b1;
    cyc(hold);
    press_a[r][c] = 1'b0;
    cyc(gap);
  endtask

  task automatic random_ready(input int n);
    for (int i = 0; i < n; i++) begin
      key_ready_a = 1'($urandom_range(0, 1));
      cyc(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] exp_q [$];
    int          ovf_base, pops_base, code, hold;
    bit          found;

    reset_a = 1'b1; reset_b = 1'b1;
    key_ready_a = 1'b0; key_ready_b = 1'b0;
    for (int r = 0; r < 4; r++) press_a[r] = '0;
    for (int r = 0; r < 3; r++) press_b[r] = '0;
    cyc(3);

    // Reset state
    check("rst_col_a",     32'(col_a), 32'hF);
    check("rst_valid_a",   32'(key_valid_a), 0);
    check("rst_code_a",    32'(key_code_a), 0);
    check("rst_release_a", 32'(key_release_a), 0);
    check("rst_overflow_a", 32'(overflow_a), 0);
    check("rst_state_a",   32'(dut_a.state_q), 32'(ST_IDLE));
    check("rst_col_b",     32'(col_b), 32'h1F);
    reset_a = 1'b0; reset_b = 1'b0;
    cyc(5);

    // Single key (2,1) held long then released
    key_ready_a = 1'b1;
    tap_a(2, 1, 2000, 0);
    wait_obs(2, 400);
    cyc(100);
    check("k21_count", 32'(pending()), 2);
    take(v); check("k21_press",   v, ev(0, 9));
    take(v); check("k21_release", v, ev(1, 9));
    check("k21_idle", 32'(dut_a.state_q), 32'(ST_IDLE));

    // Short bounce on row 1 during CONFIRM
    press_a[1][0] = 1'b1;
    cyc(30);
    check("bounce_confirm", 32'(dut_a.state_q), 32'(ST_CONFIRM));
    cyc(10);
    press_a[1][0] = 1'b0;
    cyc(200);
    check("bounce_no_event", 32'(pending()), 0);
    check("bounce_idle", 32'(dut_a.state_q), 32'(ST_IDLE));

    // Ghosting: two rows on column 0
    press_a[0][0] = 1'b1; press_a[1][0] = 1'b1;
    cyc(40);
    check("ghost_state", 32'(dut_a.state_q), 32'(ST_WAIT_CLR));
    check("ghost_col",   32'(col_a), 32'hF);
    press_a[0][0] = 1'b0; press_a[1][0] = 1'b0;
    cyc(150);
    check("ghost_idle",     32'(dut_a.state_q), 32'(ST_IDLE));
    check("ghost_no_event", 32'(pending()), 0);

    // Five events with the consumer stalled: fifth is dropped
    key_ready_a = 1'b0;
    ovf_base = ovf_a;
    tap_a(0, 2, 300, 200);
    tap_a(3, 3, 300, 200);
    press_a[1][3] = 1'b1;
    cyc(300);
    check("full_overflow_pulses", 32'(ovf_a - ovf_base), 1);
    check("full_valid",   32'(key_valid_a), 1);
    check("full_head",    32'(key_code_a), 2);
    check("full_head_rel", 32'(key_release_a), 0);

    // Release of (1,3) lands on a full FIFO; pop in the same cycle
    press_a[1][3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (dut_a.evt_push) begin
        found = 1'b1;
        key_ready_a = 1'b1;
        cyc(1);
        key_ready_a = 1'b0;
      end else begin
        cyc(1);
      end
    end
    cyc(5);
    check("pushpop_seen", 32'(found), 1);
    check("pushpop_no_overflow", 32'(ovf_a - ovf_base), 1);
    check("pushpop_popped", 32'(pending()), 1);
    take(v); check("pushpop_popped_code", v, ev(0, 2));

    // Drain in order
    key_ready_a = 1'b1;
    wait_obs(4, 60);
    cyc(10);
    check("drain_count", 32'(pending()), 4);
    take(v); check("drain0", v, ev(1, 2));
    take(v); check("drain1", v, ev(0, 15));
    take(v); check("drain2", v, ev(1, 15));
    take(v); check("drain3", v, ev(1, 7));
    check("drain_empty", 32'(key_valid_a), 0);

    // Random keys with a random-ready consumer against an event-level model
    for (int k = 0; k < 8; k++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      code = r * 4 + c;
      exp_q.push_back(ev(0, code));
      exp_q.push_back(ev(1, code));
      hold = $urandom_range(150, 500);
      press_a[r][c] = 1'b1;
      random_ready(hold);
      press_a[r][c] = 1'b0;
      random_ready($urandom_range(150, 300));
    end
    key_ready_a = 1'b1;
    wait_obs(exp_q.size(), 200);
    cyc(20);
    check("rand_count", 32'(pending()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      take(v);
      check($sformatf("rand_ev%0d", i), v, exp_q[i]);
    end

    // 3x5 instance: key (2,4), then reset while held
    press_b[2][4] = 1'b1;
    cyc(300);
    check("b_valid",   32'(key_valid_b), 1);
    check("b_code",    32'(key_code_b), 14);
    check("b_release", 32'(key_release_b), 0);
    check("b_held",    32'(dut_b.state_q), 32'(ST_HELD));
    reset_b = 1'b1;
    cyc(2);
    check("b_rst_col",   32'(col_b), 32'h1F);
    check("b_rst_valid", 32'(key_valid_b), 0);
    check("b_rst_code",  32'(key_code_b), 0);
    press_b[2][4] = 1'b0;
    cyc(3);
    reset_b = 1'b0;
    key_ready_b = 1'b1;
    pops_base = pops_b;
    cyc(400);
    check("b_no_release", 32'(pops_b - pops_base), 0);
    check("b_idle", 32'(dut_b.state_q), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
